rc4_stream: RTL and testbench
=============================

Name: rc4_stream

Overview:
Parametrised RC4 stream-cipher engine. It performs the key schedule (KSA) on a loaded key of up to MAX_KEY_BYTES bytes, then optionally discards the first DROP_N keystream bytes (RC4-drop[n]). After that it XORs a byte stream with the keystream using valid/ready handshakes on both input and output. It sits between the byte-stream source and sink and supersedes the fixed-size rc4 core for continuous encrypt/decrypt.

Parameters:
MAX_KEY_BYTES, 16, maximum key length in bytes; sets the width of key (1..256).
DROP_N, 0, number of keystream bytes generated and discarded after KSA, before streaming (0..65535).

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  1-cycle request to (re)key using key/key_length.
key  input  MAX_KEY_BYTES*8  key bytes; byte n at key[n*8 +: 8], byte 0 is first.
key_length  input  8  number of valid key bytes.
key_err  output  1  1-cycle pulse: start rejected because of an illegal key_length.
ks_ready  output  1  high while in STREAM (KSA and drop complete).
in_valid  input  1  input byte valid.
in_data  input  8  plaintext/ciphertext byte.
in_ready  output  1  engine accepts in_data this cycle.
out_valid  output  1  output byte valid.
out_data  output  8  in_data XOR keystream byte.
out_ready  input  1  sink accepts out_data.

Behaviour:
- Reset (async): state=IDLE, i=j=0, key_err=0, ks_ready=0, in_ready=0, out_valid=0, out_data=0, keystream buffer empty. S-box contents undefined.
- S-box: internal 256x8 register array with combinational reads and up to two writes per cycle (swap).
- States: IDLE, INIT, KSA, DROP, STREAM.
- IDLE: start with 1<=key_length<=MAX_KEY_BYTES -> INIT next cycle. Otherwise key_err pulses the cycle after start and the state stays IDLE.
- INIT: 256 cycles, S[c]=c for c=0..255; then KSA with i=j=0.
- KSA: 256 cycles, one i per cycle. j=j+S[i]+key[(i mod key_length)] mod 256; swap S[i],S[j]. After i=255, set i=j=0 and go to DROP, or to STREAM if DROP_N=0.
- Keystream generator, 2 cycles per byte:
  - Phase A: i=i+1; j=j+S[i]; swap S[i],S[j].
  - Phase B: K=S[(S[i]+S[j]) mod 256] is written into a 1-entry keystream buffer.
  - The generator stalls while the buffer is full.
- DROP: generates and discards DROP_N bytes (2*DROP_N cycles), then goes to STREAM.
- STREAM:
  - ks_ready=1.
  - in_ready = buffer full AND (!out_valid OR out_ready).
  - Transfer when in_valid&&in_ready: out_data<=in_data^K, out_valid<=1 next cycle, buffer emptied.
  - out_valid/out_data hold stable until out_ready. out_valid clears on out_ready with no new transfer.
  - Sustained throughput: 1 byte per 2 cycles. Latency from accepted input to out_valid: 1 cycle.
- start during STREAM with a legal key:
  - Discards any pending output: out_valid=0, buffer emptied.
  - ks_ready=0; goes to INIT.
  - With an illegal key: key_err pulses and streaming continues unaffected.
- start during INIT/KSA/DROP is ignored; the key is not re-sampled.
- key/key_length are sampled only on an accepted start. Callers hold them stable through KSA; the block does not register the whole key.
- All index arithmetic is 8-bit wrap-around (i, j, S sums).
- Async reset mid-operation returns to IDLE immediately; no output is produced until a new start.

Test Plan:
- Key "Key" (4B 65 79, len 3), DROP_N=0, stream 9 bytes "Plaintext" -> out BB F3 16 E8 D9 40 AF 0A D3. ks_ready asserts 513 cycles after the accepted start (256 INIT + 256 KSA + 1).
- Key "Secret", input "Attack at dawn" with out_ready toggled randomly -> out 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5. out_data is stable while out_valid&&!out_ready.
- Key 01 02 03 04 05, input 16 bytes of 00 -> keystream B2 39 63 05 F0 3D C0 27 CC C3 52 4A 0A 11 18 A8. Rebuilt with DROP_N=16 -> first output bytes 69 82 94 4F 18 FC 82 D5.
- start with key_length=0, then with key_length=MAX_KEY_BYTES+1 -> key_err pulses once each, state stays IDLE, ks_ready=0.
- Mid-stream re-key: stream 3 bytes under "Key", then start with "Wiki" while out_valid is pending -> pending byte dropped. Then "pedia" -> 10 21 BF 04 20.
- rst_n asserted during KSA and during STREAM -> all outputs 0 asynchronously. A following start with "Key" reproduces the first vector exactly.

Source files
------------

// File: rtl/rc4_stream.sv
// RC4 stream engine: key schedule, optional RC4-drop[n] discard, then a byte-stream XOR
// with valid/ready on both sides. Keystream bytes are produced two cycles apart into a 1-entry buffer.
module rc4_stream #(
    parameter int unsigned MAX_KEY_BYTES = 16,
    parameter int unsigned DROP_N        = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [MAX_KEY_BYTES*8-1:0] key,
    input  logic [7:0]                 key_length,
    output logic                       key_err,
    output logic                       ks_ready,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready
);

    typedef enum logic [2:0] {IDLE, INIT, KSA, DROP, STREAM} state_e;

    localparam logic [8:0]  MAX_LEN  = 9'(MAX_KEY_BYTES);
    localparam logic [15:0] DROP_CNT = 16'(DROP_N);

    state_e      state_q, state_d;
    logic [7:0]  i_q, i_d, j_q, j_d;
    logic [7:0]  kidx_q, kidx_d, klen_q, klen_d;
    logic        phase_q, phase_d;
    logic        buf_full_q, buf_full_d;
    logic [7:0]  buf_q, buf_d;
    logic [15:0] drop_q, drop_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        key_err_q, key_err_d;

    logic [7:0]  s_q [256];
    logic        we_a, we_b;
    logic [7:0]  addr_a, addr_b, wd_a, wd_b;

    logic        key_ok, in_ready_int, xfer;
    logic [7:0]  key_byte;
    logic [7:0]  i_inc, s_inc, j_gen, s_jgen, k_idx, k_byte;
    logic [7:0]  s_i, j_ksa, s_jksa;

    always_comb begin
        key_byte = '0;
        for (int unsigned b = 0; b < MAX_KEY_BYTES; b++) begin
            if (kidx_q == 8'(b)) key_byte = key[b*8 +: 8];
        end
    end

    always_comb begin
        key_ok       = (key_length != 8'd0) && ({1'b0, key_length} <= MAX_LEN);
        in_ready_int = (state_q == STREAM) && buf_full_q && (!out_valid_q || out_ready);
        xfer         = in_valid && in_ready_int;

        i_inc  = i_q + 8'd1;
        s_inc  = s_q[i_inc];
        j_gen  = j_q + s_inc;
        s_jgen = s_q[j_gen];
        k_idx  = s_q[i_q] + s_q[j_q];
        k_byte = s_q[k_idx];

        s_i    = s_q[i_q];
        j_ksa  = j_q + s_i + key_byte;
        s_jksa = s_q[j_ksa];
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        kidx_d      = kidx_q;
        klen_d      = klen_q;
        phase_d     = phase_q;
        buf_full_d  = buf_full_q;
        buf_d       = buf_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        key_err_d   = 1'b0;
        we_a        = 1'b0;
        we_b        = 1'b0;
        addr_a      = '0;
        addr_b      = '0;
        wd_a        = '0;
        wd_b        = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (key_ok) begin
                        state_d = INIT;
                        i_d     = '0;
                        j_d     = '0;
                        kidx_d  = '0;
                        klen_d  = key_length;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end

            INIT: begin
                we_a   = 1'b1;
                addr_a = i_q;
                wd_a   = i_q;
                i_d    = i_inc;
                if (i_q == 8'hFF) begin
                    state_d = KSA;
                    j_d     = '0;
                    kidx_d  = '0;
                end
            end

            KSA: begin
                we_a   = 1'b1;
                addr_a = i_q;
                wd_a   = s_jksa;
                we_b   = 1'b1;
                addr_b = j_ksa;
                wd_b   = s_i;
                i_d    = i_inc;
                j_d    = j_ksa;
                kidx_d = (kidx_q == klen_q - 8'd1) ? 8'd0 : kidx_q + 8'd1;
                if (i_q == 8'hFF) begin
                    j_d     = '0;
                    phase_d = 1'b0;
                    drop_d  = DROP_CNT;
                    state_d = (DROP_N == 0) ? STREAM : DROP;
                end
            end

            DROP, STREAM: begin
                if (xfer) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data ^ buf_q;
                    buf_full_d  = 1'b0;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end

                // Phase A (swap) may run while the buffer is still full; only phase B waits
                // for space, which keeps the sustained rate at one byte per two cycles.
                if (!phase_q) begin
                    i_d     = i_inc;
                    j_d     = j_gen;
                    we_a    = 1'b1;
                    addr_a  = i_inc;
                    wd_a    = s_jgen;
                    we_b    = 1'b1;
                    addr_b  = j_gen;
                    wd_b    = s_inc;
                    phase_d = 1'b1;
                end else if (state_q == DROP) begin
                    phase_d = 1'b0;
                    drop_d  = drop_q - 16'd1;
                    if (drop_q == 16'd1) state_d = STREAM;
                end else if (!buf_full_q || xfer) begin
                    buf_d      = k_byte;
                    buf_full_d = 1'b1;
                    phase_d    = 1'b0;
                end

                if (state_q == STREAM && start) begin
                    if (key_ok) begin
                        state_d     = INIT;
                        i_d         = '0;
                        j_d         = '0;
                        kidx_d      = '0;
                        klen_d      = key_length;
                        phase_d     = 1'b0;
                        buf_full_d  = 1'b0;
                        out_valid_d = 1'b0;
                        we_a        = 1'b0;
                        we_b        = 1'b0;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            kidx_q      <= '0;
            klen_q      <= '0;
            phase_q     <= 1'b0;
            buf_full_q  <= 1'b0;
            buf_q       <= '0;
            drop_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            kidx_q      <= kidx_d;
            klen_q      <= klen_d;
            phase_q     <= phase_d;
            buf_full_q  <= buf_full_d;
            buf_q       <= buf_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            key_err_q   <= key_err_d;
        end
    end

    // S-box has no reset; INIT rewrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (we_a) s_q[addr_a] <= wd_a;
        if (we_b) s_q[addr_b] <= wd_b;
    end

    assign key_err   = key_err_q;
    assign ks_ready  = (state_q == STREAM);
    assign in_ready  = in_ready_int;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_rc4_stream.sv
// Scoreboard bench for rc4_stream: two instances (DROP_N=0 and DROP_N=16) share stimulus,
// selected by sel; expected bytes are queued at input acceptance and popped on output.
module tb_rc4_stream;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sel = 1'b0;
    logic [127:0] key = '0;
    logic [7:0]   key_length = '0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = '0;
    logic         out_ready = 1'b1;

    logic         key_err0, ks_ready0, in_ready0, out_valid0;
    logic [7:0]   out_data0;
    logic         key_err1, ks_ready1, in_ready1, out_valid1;
    logic [7:0]   out_data1;

    logic         key_err, ks_ready, in_ready, out_valid;
    logic [7:0]   out_data;

    assign key_err   = sel ? key_err1   : key_err0;
    assign ks_ready  = sel ? ks_ready1  : ks_ready0;
    assign in_ready  = sel ? in_ready1  : in_ready0;
    assign out_valid = sel ? out_valid1 : out_valid0;
    assign out_data  = sel ? out_data1  : out_data0;

    rc4_stream #(.MAX_KEY_BYTES(16), .DROP_N(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .key(key), .key_length(key_length),
        .key_err(key_err0), .ks_ready(ks_ready0), .in_valid(in_valid & ~sel), .in_data(in_data),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready)
    );

    rc4_stream #(.MAX_KEY_BYTES(16), .DROP_N(16)) u_dut_drop (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .key(key), .key_length(key_length),
        .key_err(key_err1), .ks_ready(ks_ready1), .in_valid(in_valid & sel), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         rdy_mode = 0;
    logic [7:0] exp_q [$];

    logic [7:0] CT_KEY  [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] CT_SEC  [14] = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38,
                                 8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
    logic [7:0] KS_05   [16] = '{8'hB2, 8'h39, 8'h63, 8'h05, 8'hF0, 8'h3D, 8'hC0, 8'h27,
                                 8'hCC, 8'hC3, 8'h52, 8'h4A, 8'h0A, 8'h11, 8'h18, 8'hA8};
    logic [7:0] KS_DROP [8]  = '{8'h69, 8'h82, 8'h94, 8'h4F, 8'h18, 8'hFC, 8'h82, 8'hD5};
    logic [7:0] CT_WIKI [5]  = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] str_key(input string s);
        logic [127:0] k = '0;
        for (int i = 0; i < s.len(); i++) k[i*8 +: 8] = s[i];
        return k;
    endfunction

    // out_ready policy: 0 = always ready, 1 = random, 2 = stalled
    always begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    logic       held_v = 1'b0;
    logic [7:0] held_d = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("unexpected_out", 32'(out_data), 32'h100);
            else check_eq("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            held_v = 1'b0;
        end else if (out_valid) begin
            if (held_v) check_eq("hold_stable", 32'(out_data), 32'(held_d));
            held_v = 1'b1;
            held_d = out_data;
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic do_start(input logic [127:0] k, input logic [7:0] len);
        @(posedge clk);
        #1;
        start      = 1'b1;
        key        = k;
        key_length = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_ready(input int exp_cycles, input string tag);
        int n = 1;
        while (!ks_ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, 32'(n), 32'(exp_cycles));
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] e);
        int n  = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (n < 1000) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (ok) exp_q.push_back(e);
        else check_eq("send_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (ok) check_eq("latency", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_key_err"},   32'(key_err),   32'd0);
        check_eq({tag, "_ks_ready"},  32'(ks_ready),  32'd0);
        check_eq({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_out_data"},  32'(out_data),  32'd0);
    endtask

    string      pt_key  = "Plaintext";
    string      pt_sec  = "Attack at dawn";
    string      pt_wiki = "pedia";
    logic [127:0] k05   = 128'h05_04_03_02_01;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // illegal key lengths while idle
        do_start(str_key("Key"), 8'd0);
        check_eq("kerr0_pulse", 32'(key_err), 32'd1);
        @(posedge clk);
        #1;
        check_eq("kerr0_clear", 32'(key_err), 32'd0);
        do_start(str_key("Key"), 8'd17);
        check_eq("kerr17_pulse", 32'(key_err), 32'd1);
        @(posedge clk);
        #1;
        check_eq("kerr17_clear", 32'(key_err), 32'd0);
        repeat (600) @(posedge clk);
        #1;
        check_eq("kerr_idle_ks", 32'(ks_ready), 32'd0);
        check_eq("kerr_idle_in", 32'(in_ready), 32'd0);

        // "Key" / "Plaintext"
        do_start(str_key("Key"), 8'd3);
        check_eq("key_no_err", 32'(key_err), 32'd0);
        wait_ready(513, "ks_latency");
        for (int i = 0; i < 9; i++) send(pt_key[i], CT_KEY[i]);
        drain();

        // illegal re-key while streaming leaves STREAM alone
        do_start('0, 8'd0);
        check_eq("kerr_stream_pulse", 32'(key_err), 32'd1);
        check_eq("kerr_stream_ks", 32'(ks_ready), 32'd1);

        // "Secret" with random backpressure
        rdy_mode = 1;
        do_start(str_key("Secret"), 8'd6);
        wait_ready(513, "ks_latency_sec");
        for (int i = 0; i < 14; i++) send(pt_sec[i], CT_SEC[i]);
        drain();
        rdy_mode = 0;

        // raw keystream for 01..05
        do_start(k05, 8'd5);
        wait_ready(513, "ks_latency_05");
        for (int i = 0; i < 16; i++) send(8'h00, KS_05[i]);
        drain();

        // DROP_N=16 instance
        sel = 1'b1;
        do_start(k05, 8'd5);
        wait_ready(545, "ks_latency_drop");
        for (int i = 0; i < 8; i++) send(8'h00, KS_DROP[i]);
        drain();
        sel = 1'b0;

        // mid-stream re-key drops the pending byte
        do_start(str_key("Key"), 8'd3);
        wait_ready(513, "ks_latency_rk");
        send(pt_key[0], CT_KEY[0]);
        send(pt_key[1], CT_KEY[1]);
        drain();
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(pt_key[2], CT_KEY[2]);
        repeat (3) @(posedge clk);
        #1;
        check_eq("pending_valid", 32'(out_valid), 32'd1);
        check_eq("pending_data", 32'(out_data), 32'(CT_KEY[2]));
        do_start(str_key("Wiki"), 8'd4);
        check_eq("rekey_drop_valid", 32'(out_valid), 32'd0);
        check_eq("rekey_ks", 32'(ks_ready), 32'd0);
        exp_q.delete();
        rdy_mode = 0;
        wait_ready(513, "ks_latency_wiki");
        for (int i = 0; i < 5; i++) send(pt_wiki[i], CT_WIKI[i]);
        drain();

        // async reset during KSA
        do_start(str_key("Key"), 8'd3);
        repeat (300) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_ksa");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        check_eq("rst_ksa_stays_idle", 32'(ks_ready), 32'd0);

        // async reset during STREAM with a byte pending
        do_start(str_key("Key"), 8'd3);
        wait_ready(513, "ks_latency_prerst");
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(pt_key[0], CT_KEY[0]);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_stream");
        exp_q.delete();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // first vector again after reset
        do_start(str_key("Key"), 8'd3);
        wait_ready(513, "ks_latency_postrst");
        for (int i = 0; i < 9; i++) send(pt_key[i], CT_KEY[i]);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
